// File: rtl/kbd_scanner_if.sv
// rtl/kbd_scanner_if.sv - key matrix cache write port
// Ports:
//   wr_valid  master->slave  write request
//   wr_ready  slave->master  write accepted this cycle
//   wr_addr   master->slave  cache address, 17'hE800 + row
//   wr_data   master->slave  committed row value, active-low
interface kbd_scanner_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/kbd_scanner.sv
// rtl/kbd_scanner.sv - PET keyboard matrix scanner with per-row debounce
// Ports:
//   clk            system clock, rising edge
//   res_b          asynchronous active-low reset
//   scan_en        scan enable, honoured at row boundaries
//   force_refresh  pulse: the next full frame writes every row
//   col_in[7:0]    raw active-low column sense, asynchronous
//   row_sel[3:0]   row index to the external decoder
//   frame_done     1-cycle pulse when the last row completes
//   wr             cache write port (master)
module kbd_scanner #(
  parameter int ROWS           = 10,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          res_b,
  input  logic          scan_en,
  input  logic          force_refresh,
  input  logic [7:0]    col_in,
  output logic [3:0]    row_sel,
  output logic          frame_done,
  kbd_scanner_if.master wr
);
  localparam int SW = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, DRIVE, EVAL, WRITE} state_t;
  state_t state, state_nx;

  logic [7:0]    col_s1, col_s2;
  logic [3:0]    row;
  logic [SW-1:0] settle_cnt;
  logic [7:0]    stable [ROWS];
  logic [7:0]    cand   [ROWS];
  logic [2:0]    cnt    [ROWS];
  logic          refresh_pend, refresh_act;

  logic       hit_stable, hit_cand, commit, go_write, advance, last_row, frame_entry;
  logic [2:0] cnt_inc, cnt_new;

  always_comb begin
    hit_stable = (col_s2 == stable[row]);
    hit_cand   = (col_s2 == cand[row]);
    cnt_inc    = (cnt[row] == 3'd7) ? 3'd7 : cnt[row] + 3'd1;
    // A sample differing from both stable and cand starts a new run of 1,
    // so DEBOUNCE_SCANS == 1 commits on the first differing sample.
    cnt_new    = hit_stable ? 3'd0 : (hit_cand ? cnt_inc : 3'd1);
    commit     = !hit_stable && (cnt_new == 3'(DEBOUNCE_SCANS));
    go_write   = commit || refresh_act;
    last_row   = (row == 4'(ROWS - 1));
    advance    = ((state == EVAL) && !go_write) || ((state == WRITE) && wr.wr_ready);
    // Every entry into row-0 DRIVE starts a new frame.
    frame_entry = ((state == IDLE) && scan_en) || (advance && scan_en && last_row);
  end

  always_ff @(posedge clk or negedge res_b) begin
    if (!res_b) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (scan_en) state_nx = DRIVE;
      DRIVE:   if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nx = EVAL;
      EVAL:    state_nx = go_write ? WRITE : (scan_en ? DRIVE : IDLE);
      WRITE:   if (wr.wr_ready) state_nx = scan_en ? DRIVE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // row is left untouched when advancing into IDLE, so row_sel keeps
  // pointing at the last row driven.
  always_comb begin
    wr.wr_valid = (state == WRITE);
    wr.wr_addr  = 17'hE800 + {13'd0, row};
    wr.wr_data  = stable[row];
    frame_done  = advance && last_row;
    row_sel     = row;
  end

  always_ff @(posedge clk or negedge res_b) begin
    if (!res_b) begin
      col_s1       <= 8'hFF;
      col_s2       <= 8'hFF;
      row          <= 4'd0;
      settle_cnt   <= '0;
      refresh_pend <= 1'b0;
      refresh_act  <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        stable[i] <= 8'hFF;
        cand[i]   <= 8'hFF;
        cnt[i]    <= 3'd0;
      end
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;

      settle_cnt <= ((state == DRIVE) && (state_nx == DRIVE)) ? settle_cnt + SW'(1) : '0;

      if ((state == IDLE) && scan_en)
        row <= 4'd0;
      else if (advance && scan_en)
        row <= last_row ? 4'd0 : row + 4'd1;

      // A pulse during a refresh frame stays pending and arms the next one.
      if (force_refresh)    refresh_pend <= 1'b1;
      else if (frame_entry) refresh_pend <= 1'b0;

      if (frame_entry && refresh_pend) refresh_act <= 1'b1;
      else if (advance && last_row)    refresh_act <= 1'b0;

      if (state == EVAL) begin
        // Every EVAL outcome leaves cand equal to the sample.
        cand[row] <= col_s2;
        cnt[row]  <= commit ? 3'd0 : cnt_new;
        if (commit) stable[row] <= col_s2;
      end
    end
  end
endmodule

// File: tb/tb_kbd_scanner.sv
// tb/tb_kbd_scanner.sv - self-checking bench for kbd_scanner
module tb_kbd_scanner;
  localparam int ROWS    = 10;
  localparam int SETTLE  = 8;
  localparam int DEB     = 4;
  localparam int ROW_CYC = SETTLE + 1;
  localparam int HDEPTH  = 128;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic       clk = 1'b0;
  logic       res_b = 1'b0;
  logic       scan_en = 1'b0;
  logic       force_refresh = 1'b0;
  logic [7:0] col_in;
  logic [3:0] row_sel;
  logic       frame_done;
  logic [7:0] key_mat [ROWS];

  kbd_scanner_if wr ();

  kbd_scanner #(.ROWS(ROWS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
    .clk           (clk),
    .res_b         (res_b),
    .scan_en       (scan_en),
    .force_refresh (force_refresh),
    .col_in        (col_in),
    .row_sel       (row_sel),
    .frame_done    (frame_done),
    .wr            (wr)
  );

  always #5 clk = ~clk;

  // Physical matrix: the selected row's keys appear on the columns.
  assign col_in = key_mat[row_sel];

  int checks = 0;
  int errors = 0;

  // Reference model: per-row committed value plus the sample history since
  // the last commit; a row commits once its trailing run of identical,
  // differing samples is exactly DEB long.
  logic [7:0] stable_m [ROWS];
  logic [7:0] hist [ROWS][HDEPTH];
  int         hlen [ROWS];
  bit         pend_m;
  wr_t        exp_q[$];
  wr_t        act_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++) begin
      stable_m[r] = 8'hFF;
      hlen[r] = 0;
    end
    pend_m = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_row(input int r, input bit refr);
    logic [7:0] s;
    int run;
    bit cm;
    wr_t e;
    s = key_mat[r];
    run = 0;
    cm = 1'b0;
    if (hlen[r] < HDEPTH) begin
      hist[r][hlen[r]] = s;
      hlen[r]++;
    end
    for (int i = hlen[r] - 1; i >= 0; i--) begin
      if (hist[r][i] != s) break;
      run++;
    end
    if ((s != stable_m[r]) && (run == DEB)) begin
      stable_m[r] = s;
      hlen[r] = 0;
      cm = 1'b1;
    end
    if (cm || refr) begin
      e.addr = 17'hE800 + 17'(r);
      e.data = stable_m[r];
      exp_q.push_back(e);
    end
  endfunction

  // ready_mode: 0 always ready, 1 random, 2 stall first write for 20 cycles.
  // exp_len != 0 also checks frame length and the row_sel walk (idle frames).
  task automatic run_frame(input int pulse_at, input int ready_mode, input int exp_len);
    bit refr, done, hold_ok, stall_done, path_ok;
    int cyc, vcnt, n;
    logic [16:0] h_addr;
    logic [7:0]  h_data;
    logic [3:0]  h_row;
    wr_t a;
    done = 0; hold_ok = 1; stall_done = 0; path_ok = 1;
    cyc = 0; vcnt = 0;
    h_addr = '0; h_data = '0; h_row = '0;
    refr = pend_m;
    pend_m = 1'b0;
    exp_q.delete();
    act_q.delete();
    for (int r = 0; r < ROWS; r++) model_row(r, refr);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      force_refresh = (cyc == pulse_at);
      if (cyc == pulse_at) pend_m = 1'b1;
      case (ready_mode)
        0:       wr.wr_ready = 1'b1;
        1:       wr.wr_ready = ($urandom_range(0, 2) != 0);
        default: wr.wr_ready = stall_done || (wr.wr_valid && vcnt >= 20);
      endcase
      #1;
      cyc++;
      if (exp_len != 0)
        path_ok &= (row_sel == 4'((cyc - 1) / ROW_CYC)) && !wr.wr_valid;
      if (wr.wr_valid) begin
        if (vcnt == 0) begin
          h_addr = wr.wr_addr; h_data = wr.wr_data; h_row = row_sel;
        end else begin
          hold_ok &= (wr.wr_addr == h_addr) && (wr.wr_data == h_data) && (row_sel == h_row);
        end
        vcnt++;
        if (wr.wr_ready) begin
          check("wr_hold_stable", 32'(hold_ok), 32'd1);
          check("wr_addr_matches_row", 32'(wr.wr_addr), 32'(17'hE800 + 17'(row_sel)));
          if (ready_mode == 2 && !stall_done) begin
            check("stall_valid_cycles", 32'(vcnt), 32'd21);
            stall_done = 1;
          end
          a.addr = wr.wr_addr;
          a.data = wr.wr_data;
          act_q.push_back(a);
          vcnt = 0;
          hold_ok = 1;
        end
      end
      if (frame_done) begin
        done = 1;
        check("frame_done_row", 32'(row_sel), 32'(ROWS - 1));
      end
    end
    force_refresh = 1'b0;
    check("frame_done_seen", 32'(done), 32'd1);
    if (exp_len != 0) begin
      check("frame_len", 32'(cyc), 32'(exp_len));
      check("row_sel_walk", 32'(path_ok), 32'd1);
    end
    check("write_count", 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("write_addr", 32'(act_q[i].addr), 32'(exp_q[i].addr));
      check("write_data", 32'(act_q[i].data), 32'(exp_q[i].data));
    end
  endtask

  task automatic wait_valid(output bit seen);
    int cyc;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      wr.wr_ready = 1'b0;
      #1;
      cyc++;
      seen = wr.wr_valid;
    end
  endtask

  initial begin
    bit seen, idle_ok;
    for (int r = 0; r < ROWS; r++) key_mat[r] = 8'hFF;
    wr.wr_ready = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check("rst_row_sel", 32'(row_sel), 32'd0);
    check("rst_wr_valid", 32'(wr.wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr.wr_addr), 32'h0E800);
    check("rst_wr_data", 32'(wr.wr_data), 32'hFF);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    @(negedge clk);
    res_b = 1'b1;
    @(negedge clk);
    scan_en = 1'b1;

    // Idle keys: fixed 90-cycle frames, no writes.
    repeat (3) run_frame(-1, 0, ROWS * ROW_CYC);

    // Row 3 held: one write on the 4th sample, then silence; release likewise.
    key_mat[3] = 8'hFE;
    repeat (DEB - 1) run_frame(-1, 1, 0);
    run_frame(-1, 1, 0);
    check("row3_press_count", 32'(act_q.size()), 32'd1);
    check("row3_press_addr", 32'(act_q.size() > 0 ? act_q[0].addr : 17'd0), 32'h0E803);
    check("row3_press_data", 32'(act_q.size() > 0 ? act_q[0].data : 8'd0), 32'hFE);
    repeat (2) run_frame(-1, 1, 0);
    key_mat[3] = 8'hFF;
    repeat (DEB - 1) run_frame(-1, 1, 0);
    run_frame(-1, 1, 0);
    check("row3_release_addr", 32'(act_q.size() > 0 ? act_q[0].addr : 17'd0), 32'h0E803);
    check("row3_release_data", 32'(act_q.size() > 0 ? act_q[0].data : 8'd0), 32'hFF);

    // Row 5 bounces every frame: never commits.
    for (int f = 0; f < 6; f++) begin
      key_mat[5] = (f % 2 == 0) ? 8'hFE : 8'hFF;
      run_frame(-1, 1, 0);
    end

    // Refresh pulse mid-frame: next frame rewrites all rows, then quiet.
    run_frame(30, 1, 0);
    run_frame(-1, 1, 0);
    check("refresh_write_count", 32'(act_q.size()), 32'(ROWS));
    check("refresh_row5_data", 32'(act_q.size() > 5 ? act_q[5].data : 8'd0), 32'hFF);
    run_frame(-1, 1, 0);
    check("post_refresh_count", 32'(act_q.size()), 32'd0);

    // Commit held off by wr_ready for 20 cycles.
    key_mat[2] = 8'hF0;
    repeat (DEB - 1) run_frame(-1, 1, 0);
    run_frame(-1, 2, 0);

    // scan_en dropped during row 7 write: write completes, scanner idles on row 7.
    key_mat[7] = 8'hFB;
    repeat (DEB - 1) run_frame(-1, 1, 0);
    exp_q.delete();
    for (int r = 0; r < 8; r++) model_row(r, 1'b0);
    wait_valid(seen);
    check("row7_write_seen", 32'(seen), 32'd1);
    check("row7_addr", 32'(wr.wr_addr), 32'h0E807);
    check("row7_data", 32'(wr.wr_data), 32'hFB);
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("row7_valid_held", 32'(wr.wr_valid), 32'd1);
    wr.wr_ready = 1'b1;
    #1;
    check("row7_no_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    wr.wr_ready = 1'b0;
    idle_ok = 1;
    repeat (20) begin
      #1;
      idle_ok &= !wr.wr_valid && (row_sel == 4'd7) && !frame_done;
      @(negedge clk);
    end
    check("idle_holds_row7", 32'(idle_ok), 32'd1);
    scan_en = 1'b1;
    run_frame(-1, 1, 0);

    // Reset in the middle of a write.
    key_mat[1] = 8'h00;
    repeat (DEB - 1) run_frame(-1, 1, 0);
    wait_valid(seen);
    check("row1_write_seen", 32'(seen), 32'd1);
    check("row1_addr", 32'(wr.wr_addr), 32'h0E801);
    res_b = 1'b0;
    #1;
    check("async_rst_wr_valid", 32'(wr.wr_valid), 32'd0);
    check("async_rst_row_sel", 32'(row_sel), 32'd0);
    check("async_rst_wr_addr", 32'(wr.wr_addr), 32'h0E800);
    check("async_rst_wr_data", 32'(wr.wr_data), 32'hFF);
    check("async_rst_frame_done", 32'(frame_done), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    res_b = 1'b1;

    // Random key activity with random wr_ready and one refresh pulse.
    for (int f = 0; f < 14; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 3))
            0:       key_mat[r] = 8'hFF;
            1:       key_mat[r] = 8'hFE;
            2:       key_mat[r] = 8'h7F;
            default: key_mat[r] = 8'($urandom);
          endcase
        end
      end
      run_frame((f == 5) ? 40 : -1, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kbd_scanner.md
# kbd_scanner

Scans a physical PET keyboard matrix (10 rows × 8 active-low columns), debounces each row, and publishes changed rows as write transactions into the keyboard matrix cache at $E800–$E809. It is the writer side of the key matrix cache, which the PIA1 port B intercept reads. It sits between the keyboard connector pins and the bus arbiter's write port; committed writes are indistinguishable from RPi-originated cache writes.

## Interface
Parameters:
- ROWS, 10: number of matrix rows scanned, 1..16.
- SETTLE_CYCLES, 8: cycles row_sel is held before sampling; minimum 3, which covers the 2-flop synchronizer plus 1 cycle of external settling.
- DEBOUNCE_SCANS, 4: consecutive identical differing samples required to commit a row change; 1..7.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- res_b  in  1  asynchronous, active-low reset.
- scan_en  in  1  enables scanning; sampled at row boundaries.
- force_refresh  in  1  single-cycle pulse; the next complete frame writes every row regardless of change.
- col_in  in  8  raw column sense, active-low (0 = key pressed), asynchronous; passes through a 2-flop synchronizer.
- row_sel  out  4  row index driven to the external row decoder.
- wr_valid  out  1  write request to the cache.
- wr_ready  in  1  cache/arbiter accepts the write.
- wr_addr  out  17  equals 17'hE800 + row.
- wr_data  out  8  committed row value, active-low.
- frame_done  out  1  1-cycle pulse when row ROWS-1 completes.

## Operation
- State per row: stable[r] (8 bits, reset 8'hFF), cand[r] (8 bits, reset 8'hFF), cnt[r] (3 bits, reset 0).
- The FSM has four states: IDLE, DRIVE, EVAL and WRITE.
- IDLE: row_sel holds its value. Move to DRIVE with row = 0 when scan_en = 1.
- DRIVE: row_sel = row. Count SETTLE_CYCLES cycles, then move to EVAL.
- EVAL (1 cycle): let s = synchronized col_in.
  - If s == stable[r]: cnt = 0, cand = s, and there is no commit.
  - Else if s == cand[r]: cnt = cnt + 1 (saturating). When the new cnt == DEBOUNCE_SCANS, commit.
  - Else: cand = s, cnt = 1. Commit immediately if DEBOUNCE_SCANS == 1.
  - Commit: stable[r] = s, cnt = 0, and go to WRITE.
  - Go to WRITE also when the refresh flag is set for this frame.
  - Otherwise advance to the next row.
- WRITE: wr_valid = 1, with wr_addr and wr_data = stable[r] held constant until the cycle where wr_valid & wr_ready. The next cycle advances to the next row.
- Advance rules:
  - For row < ROWS-1: row++ and go to DRIVE.
  - For row == ROWS-1: row = 0, pulse frame_done, and clear the refresh flag if this frame was a refresh frame.
  - If scan_en = 0 at advance, go to IDLE instead of DRIVE.
- force_refresh: sets a pending flag. The flag arms at the next row-0 DRIVE entry and covers that whole frame. A pulse arriving mid-refresh-frame re-arms for the following frame.
- scan_en deasserted mid-row: the current row, including any pending WRITE, completes first. No write is ever abandoned except by reset.

## Timing
- Reset values: row_sel = 0, wr_valid = 0, wr_addr = 17'hE800, wr_data = 8'hFF, frame_done = 0, state = IDLE, all stable and cand = 8'hFF, all cnt = 0, refresh flag = 0.
- Row period without a write: SETTLE_CYCLES + 1 cycles. With a write: add 1 + the wait cycles for wr_ready.
- Frame with no writes: ROWS × (SETTLE_CYCLES + 1) cycles. With defaults this is 90 cycles.
- Latency from a col_in change to its sample is 2 cycles (synchronizer). A change is visible to EVAL only if it lands ≥2 cycles before EVAL.
- wr_valid rises in the cycle after EVAL.
- Handshake rules: wr_valid must not drop before acceptance, and wr_addr/wr_data must not change while wr_valid = 1. wr_ready may already be high when valid rises, giving single-cycle acceptance.
- Reset during WRITE: wr_valid drops asynchronously, and the write is lost.
- DRIVE always re-counts from 0 on entry.

## Test plan
- Reset, scan_en = 1, col_in = 8'hFF for 3 frames -> no wr_valid; frame_done every 90 cycles; row_sel steps 0..9 and wraps.
- Hold row 3 = 8'hFE from frame 0 -> exactly one write, wr_addr = 17'hE803, wr_data = 8'hFE, in frame 3 (4th sample); no further writes while held; release -> one write of 8'hFF four frames later.
- Row 5 alternates 8'hFE/8'hFF each frame (bounce) -> no write ever issued; stable[5] stays 8'hFF.
- Commit with wr_ready held low 20 cycles -> wr_valid, wr_addr and wr_data are constant for 21 cycles; row_sel does not advance until acceptance.
- force_refresh pulse mid-frame, keys idle -> the next full frame issues 10 writes E800..E809, each 8'hFF; the following frame issues none.
- Deassert scan_en during row 7 WRITE -> the write completes, the FSM enters IDLE, and row_sel holds 7; assert res_b = 0 during a later WRITE -> wr_valid = 0 immediately, and all outputs take their reset values.
